// File: rtl/bitslip_word_align.sv
// bitslip_word_align: multi-channel word aligner for deserialised ADC lanes.
//
// Each lane runs a two-word barrel shifter and its own training FSM. A
// train_start pulse makes every lane sweep its bitslip offset from 0 upward.
// A lane locks on the first offset whose output equals TRAIN_PATTERN for
// MATCH_COUNT consecutive words, and then holds that offset. A lane that
// tries every offset without locking reports fail.
//
// Optional feature: define BITSLIP_MANUAL_EN to add manual_en/manual_count,
// which override the slip of each lane directly and hold the FSMs in IDLE.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   din             N_CH raw words, lane c = din[c*DIN_WIDTH +: DIN_WIDTH]
//   train_start     pulse: restart training on all lanes
//   manual_en       (BITSLIP_MANUAL_EN only) manual slip override
//   manual_count    (BITSLIP_MANUAL_EN only) per-lane manual slip
//   dout            aligned words, same packing as din
//   bitslip_count   current slip per lane, $clog2(DIN_WIDTH) bits each
//   locked, fail    per-lane training result
//   all_locked      registered AND of locked

module bitslip_lane #(
  parameter int                   W   = 8,
  parameter logic [W-1:0]         PAT = 8'hF0,
  parameter int                   MC  = 16,
  parameter int                   SC  = 2,
  parameter int                   SW  = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  din,
  input  logic          train_start,
  input  logic          manual_en,
  input  logic [SW-1:0] manual_slip,
  output logic [W-1:0]  dout,
  output logic [SW-1:0] slip,
  output logic          locked,
  output logic          fail
);
  localparam int             MW       = $clog2(MC + 1);
  localparam int             STW      = $clog2(SC + 1);
  localparam logic [SW-1:0]  SLIP_MAX = SW'(W - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_CHECK, S_LOCKED, S_FAIL} state_t;

  state_t         state_q, state_d;
  logic [2*W-1:0] stages_q;
  logic [W-1:0]   dout_q;
  logic [SW-1:0]  slip_q, slip_d;
  logic [MW-1:0]  match_q, match_d;
  logic [STW-1:0] settle_q, settle_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      stages_q <= '0;
      dout_q   <= '0;
      state_q  <= S_IDLE;
      slip_q   <= '0;
      match_q  <= '0;
      settle_q <= '0;
    end else begin
      // Newest word enters the top half; the window at slip straddles the
      // previous and current words, so any rotation is reachable.
      stages_q <= {din, stages_q[2*W-1:W]};
      dout_q   <= stages_q[slip_q +: W];
      state_q  <= state_d;
      slip_q   <= slip_d;
      match_q  <= match_d;
      settle_q <= settle_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    slip_d   = slip_q;
    match_d  = match_q;
    settle_d = settle_q;
    case (state_q)
      S_SETTLE: begin
        // The dout register needs one clk to reflect a new slip, so the
        // wait must cover at least that before the first comparison.
        if (settle_q == STW'(SC - 1)) begin
          state_d  = S_CHECK;
          settle_d = '0;
        end else begin
          settle_d = settle_q + STW'(1);
        end
      end
      S_CHECK: begin
        if (dout_q == PAT) begin
          match_d = match_q + MW'(1);
          if (match_q == MW'(MC - 1)) state_d = S_LOCKED;
        end else if (slip_q != SLIP_MAX) begin
          slip_d   = slip_q + SW'(1);
          match_d  = '0;
          settle_d = '0;
          state_d  = S_SETTLE;
        end else begin
          state_d = S_FAIL;
        end
      end
      default: ;
    endcase
    // Restart overrides whatever the lane was doing this cycle.
    if (train_start) begin
      state_d  = S_SETTLE;
      slip_d   = '0;
      match_d  = '0;
      settle_d = '0;
    end
    // Manual override wins over training entirely.
    if (manual_en) begin
      state_d  = S_IDLE;
      slip_d   = manual_slip;
      match_d  = '0;
      settle_d = '0;
    end
  end

  assign dout   = dout_q;
  assign slip   = slip_q;
  assign locked = (state_q == S_LOCKED);
  assign fail   = (state_q == S_FAIL);
endmodule

module bitslip_word_align #(
  parameter int                   DIN_WIDTH     = 8,
  parameter int                   N_CH          = 4,
  parameter logic [DIN_WIDTH-1:0] TRAIN_PATTERN = 8'hF0,
  parameter int                   MATCH_COUNT   = 16,
  parameter int                   SETTLE_CYCLES = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [N_CH*DIN_WIDTH-1:0]             din,
  input  logic                                  train_start,
`ifdef BITSLIP_MANUAL_EN
  input  logic                                  manual_en,
  input  logic [N_CH*$clog2(DIN_WIDTH)-1:0]     manual_count,
`endif
  output logic [N_CH*DIN_WIDTH-1:0]             dout,
  output logic [N_CH*$clog2(DIN_WIDTH)-1:0]     bitslip_count,
  output logic [N_CH-1:0]                       locked,
  output logic [N_CH-1:0]                       fail,
  output logic                                  all_locked
);
  localparam int SW = $clog2(DIN_WIDTH);

`ifdef BITSLIP_MANUAL_EN
`else
  logic               manual_en;
  logic [N_CH*SW-1:0] manual_count;
  assign manual_en    = 1'b0;
  assign manual_count = '0;
`endif

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    bitslip_lane #(
      .W   (DIN_WIDTH),
      .PAT (TRAIN_PATTERN),
      .MC  (MATCH_COUNT),
      .SC  (SETTLE_CYCLES),
      .SW  (SW)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .din         (din[c*DIN_WIDTH +: DIN_WIDTH]),
      .train_start (train_start),
      .manual_en   (manual_en),
      .manual_slip (manual_count[c*SW +: SW]),
      .dout        (dout[c*DIN_WIDTH +: DIN_WIDTH]),
      .slip        (bitslip_count[c*SW +: SW]),
      .locked      (locked[c]),
      .fail        (fail[c])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) all_locked <= 1'b0;
    else     all_locked <= &locked;
  end
endmodule

// File: tb/tb_bitslip_word_align.sv
module tb_bitslip_word_align;
  localparam int         W   = 8;
  localparam int         NC  = 2;
  localparam int         SW  = 3;
  localparam logic [7:0] PAT = 8'hF0;

  logic              clk = 1'b0;
  logic              rst, train_start;
  logic [NC*W-1:0]   din, dout;
  logic [NC*SW-1:0]  bitslip_count;
  logic [NC-1:0]     locked, fail;
  logic              all_locked;
`ifdef BITSLIP_MANUAL_EN
  logic              manual_en;
  logic [NC*SW-1:0]  manual_count;
`endif

  int total = 0;
  int bad   = 0;

  bitslip_word_align #(
    .DIN_WIDTH(W), .N_CH(NC), .TRAIN_PATTERN(PAT), .MATCH_COUNT(4), .SETTLE_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .train_start(train_start),
`ifdef BITSLIP_MANUAL_EN
    .manual_en(manual_en), .manual_count(manual_count),
`endif
    .dout(dout), .bitslip_count(bitslip_count), .locked(locked), .fail(fail),
    .all_locked(all_locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Words sampled at the last three edges: h0 newest.
  logic [NC*W-1:0] h0, h1, h2;
  always @(posedge clk) begin
    h2 <= h1;
    h1 <= h0;
    h0 <= din;
  end

  // all_locked must equal the AND of locked seen one clk earlier;
  // locked and fail must never be set together.
  logic pl = 1'b0;
  always @(negedge clk) begin
    if (rst) pl = 1'b0;
    else begin
      chk("all_locked_lag", all_locked, pl);
      chk("lock_fail_excl", |(locked & fail), 1'b0);
      pl = &locked;
    end
  end

  function automatic logic [7:0] ror8(input logic [7:0] x, input int s);
    logic [15:0] t;
    t = {x, x} >> s;
    return t[7:0];
  endfunction

  // First offset where the rotated word equals the pattern, -1 if none.
  function automatic int lock_slip(input logic [7:0] x);
    for (int s = 0; s < W; s++) if (ror8(x, s) == PAT) return s;
    return -1;
  endfunction

  // Output after an edge = window of the two words taken two and one
  // edges earlier, offset by the slip.
  function automatic logic [7:0] exp_dout(input int c, input int s);
    logic [15:0] t;
    t = {h1[c*W +: W], h2[c*W +: W]} >> s;
    return t[7:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] slip_of(input int c);
    return bitslip_count[c*SW +: SW];
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_dout"}, dout, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_fail"}, fail, 0);
    chk({tag, "_all"}, all_locked, 0);
    chk({tag, "_slip"}, bitslip_count, 0);
  endtask

  task automatic pulse_train();
    train_start = 1'b1;
    step();
    train_start = 1'b0;
  endtask

  // Hold constant words on each lane, train, and check the outcome.
  task automatic train_check(input logic [7:0] w0, input logic [7:0] w1, input string tag);
    logic [7:0] w [NC];
    int n;
    w[0] = w0;
    w[1] = w1;
    din = {w1, w0};
    pulse_train();
    n = 1;
    while (((locked | fail) != {NC{1'b1}}) && n < 60) begin
      step();
      n++;
    end
    chk({tag, "_time"}, n <= 40, 1);
    for (int c = 0; c < NC; c++) begin
      int s;
      s = lock_slip(w[c]);
      if (s >= 0) begin
        chk({tag, "_locked"}, locked[c], 1);
        chk({tag, "_slip"}, slip_of(c), s);
        chk({tag, "_dout"}, dout[c*W +: W], PAT);
      end else begin
        chk({tag, "_fail"}, fail[c], 1);
        chk({tag, "_slipmax"}, slip_of(c), W - 1);
      end
    end
    step();
    chk({tag, "_all"}, all_locked, (lock_slip(w0) >= 0) && (lock_slip(w1) >= 0));
  endtask

  initial begin
    int n;
    logic [2:0] s0, s1;
    rst = 1'b1;
    train_start = 1'b0;
    din = 16'($urandom);
`ifdef BITSLIP_MANUAL_EN
    manual_en = 1'b0;
    manual_count = '0;
`endif
    // Reset with random data present.
    repeat (3) begin
      din = 16'($urandom);
      step();
    end
    chk_reset("reset");
    rst = 1'b0;

    // Idle datapath at slip 0 with random words.
    repeat (2) begin
      din = 16'($urandom);
      step();
    end
    repeat (8) begin
      din = 16'($urandom);
      step();
      for (int c = 0; c < NC; c++) chk("idle_dout", dout[c*W +: W], exp_dout(c, 0));
    end

    // Lane0 needs slip 3, lane1 already aligned.
    train_check(8'h87, PAT, "basic");

    // Locked lanes ignore garbage: slip frozen, datapath keeps running.
    s0 = slip_of(0);
    s1 = slip_of(1);
    repeat (10) begin
      din = 16'($urandom);
      step();
      chk("hold_locked", locked, 2'b11);
      chk("hold_slip0", slip_of(0), s0);
      chk("hold_slip1", slip_of(1), s1);
      for (int c = 0; c < NC; c++) chk("hold_dout", dout[c*W +: W], exp_dout(c, (c == 0) ? s0 : s1));
    end
    din = '0;
    repeat (10) step();
    chk("zero_locked", locked, 2'b11);
    chk("zero_slip", bitslip_count, {s1, s0});
    rst = 1'b1;
    step();
    chk_reset("rst_locked");
    rst = 1'b0;

    // No pattern anywhere in lane0.
    train_check(8'h00, PAT, "fail");

    // Restart mid-sweep once lane0 reaches slip 2.
    din = {PAT, 8'h87};
    pulse_train();
    n = 0;
    while (slip_of(0) != 3'd2 && n < 40) begin
      step();
      n++;
    end
    chk("restart_reach2", slip_of(0), 2);
    pulse_train();
    chk("restart_slip0", slip_of(0), 0);
    chk("restart_unlock", locked, 0);
    chk("restart_nofail", fail, 0);
    n = 0;
    while (locked != 2'b11 && n < 40) begin
      step();
      n++;
    end
    chk("relock", locked, 2'b11);
    chk("relock_slip", slip_of(0), 3);

    // Reset mid-training: nothing resumes afterwards.
    din = {8'h87, 8'h1E};
    pulse_train();
    repeat (4) step();
    rst = 1'b1;
    step();
    chk_reset("rst_mid");
    rst = 1'b0;
    repeat (30) step();
    chk("no_resume_slip", bitslip_count, 0);
    chk("no_resume_lock", locked | fail, 0);

    // Random words, half of them rotations of the pattern.
    for (int i = 0; i < 8; i++) begin
      logic [7:0] a, b;
      a = ($urandom_range(1) == 1) ? ror8(PAT, $urandom_range(7)) : 8'($urandom);
      b = ($urandom_range(1) == 1) ? ror8(PAT, $urandom_range(7)) : 8'($urandom);
      train_check(a, b, "rand");
    end

`ifdef BITSLIP_MANUAL_EN
    manual_en = 1'b1;
    manual_count = {3'd1, 3'd5};
    din = {PAT, PAT};
    train_start = 1'b1;
    step();
    train_start = 1'b0;
    repeat (3) step();
    chk("man_slip", bitslip_count, {3'd1, 3'd5});
    chk("man_dout0", dout[7:0], 8'h87);
    chk("man_dout1", dout[15:8], ror8(PAT, 1));
    chk("man_locked", locked | fail, 0);
    manual_en = 1'b0;
    repeat (12) step();
    chk("man_keep_slip", bitslip_count, {3'd1, 3'd5});
    chk("man_idle", locked | fail, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
